tcore_mem_arbiter: RTL

// - N-channel arbiter between the per-cache lowX miss/uncached ports (instruction, data, future DMA) and a single block memory port.
// - Generalises the fixed icache/dcache lowX pair to NUM_CH channels with configurable block width.
// - One outstanding memory transaction at a time; the response is routed back to the granted channel.
// - Sits between the cache lowX interfaces and the memory/bus wrapper.

---
 rtl/tcore_mem_arbiter_pkg.sv | 18 +
 rtl/tcore_mem_arbiter_rr.sv | 53 +++++
 rtl/tcore_mem_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/tcore_mem_arbiter_pkg.sv
// Shared types and helpers for the cache-to-memory arbiter.
// Holds the arbiter FSM state encoding and the index-width helper.
// No logic; imported by the arbiter and its round-robin sub-module.
package tcore_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_MREQ,
    ARB_MWAIT,
    ARB_CRESP
  } arb_state_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcore_mem_arbiter_rr.sv
// Channel picker: one-hot grant and index among requesting channels.
// Latency: combinational. Backpressure: none, the caller decides when to use the grant.
// Round-robin from rr+1 by default; TCORE_ARB_FIXED_PRIO_EN selects lowest-index-wins.
module tcore_rr_arbiter
  import tcore_mem_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  rr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

`ifdef TCORE_ARB_FIXED_PRIO_EN
  // Pointer has no meaning for fixed priority.
  logic unused_rr;
  assign unused_rr = ^rr;

  // Lowest requesting index wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end
`else
  // Scan channels starting one past the last winner, wrapping to 0.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (!any && (j == (int'(rr) + i) % NUM_CH) && req[j]) begin
          any      = 1'b1;
          grant[j] = 1'b1;
          idx      = IDX_W'(j);
        end
      end
    end
  end
`endif

endmodule

// File: rtl/tcore_mem_arbiter.sv
// N-channel arbiter between cache miss ports and one block memory port, one transaction in flight.
// Latency: request handshake -> mem_req_valid_o next cycle; mem response -> res_valid_o next cycle.
// Backpressure: new grants only in IDLE; mem request and channel response held until accepted.
// Optional macro TCORE_ARB_FIXED_PRIO_EN: fixed priority (lowest index), rr pointer held at 0.
module tcore_mem_arbiter
  import tcore_mem_arbiter_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int BLK_SIZE = 128,
  parameter int XLEN     = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_CH-1:0]          req_valid_i,
  output logic [NUM_CH-1:0]          req_ready_o,
  input  logic [NUM_CH*XLEN-1:0]     req_addr_i,
  input  logic [NUM_CH*BLK_SIZE/8-1:0] req_wmask_i,
  input  logic [NUM_CH*BLK_SIZE-1:0] req_data_i,
  output logic [NUM_CH-1:0]          res_valid_o,
  input  logic [NUM_CH-1:0]          res_ready_i,
  output logic [BLK_SIZE-1:0]        res_data_o,
  output logic                       mem_req_valid_o,
  input  logic                       mem_req_ready_i,
  output logic [XLEN-1:0]            mem_addr_o,
  output logic [BLK_SIZE/8-1:0]      mem_wmask_o,
  output logic [BLK_SIZE-1:0]        mem_data_o,
  input  logic                       mem_res_valid_i,
  input  logic [BLK_SIZE-1:0]        mem_res_data_i
);

  localparam int MB    = BLK_SIZE / 8;
  localparam int IDX_W = idx_width(NUM_CH);

  // Latched memory request; the mask width follows the block width.
  typedef struct packed {
    logic [XLEN-1:0]     addr;
    logic [MB-1:0]       wmask;
    logic [BLK_SIZE-1:0] data;
  } mem_req_t;

  arb_state_e          state;
  mem_req_t            mreq;
  logic [IDX_W-1:0]    win;
  logic [IDX_W-1:0]    rr;
  logic [NUM_CH-1:0]   grant;
  logic [IDX_W-1:0]    gidx;
  logic                gany;
  logic [XLEN-1:0]     gaddr;
  logic [MB-1:0]       gwmask;
  logic [BLK_SIZE-1:0] gdata;

  tcore_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req   (req_valid_i),
    .rr    (rr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  // Fields of the channel that would win this cycle.
  assign gaddr  = req_addr_i[int'(gidx)*XLEN +: XLEN];
  assign gwmask = req_wmask_i[int'(gidx)*MB +: MB];
  assign gdata  = req_data_i[int'(gidx)*BLK_SIZE +: BLK_SIZE];

  // Ready is the accept pulse itself, so the channel sees it in the cycle the fields are latched.
  assign req_ready_o = (state == ARB_IDLE && !rst_i) ? grant : '0;

  assign mem_addr_o  = mreq.addr;
  assign mem_wmask_o = mreq.wmask;
  assign mem_data_o  = mreq.data;

  // Transaction FSM: grant, present to memory, wait for response, return it to the winner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= ARB_IDLE;
      mreq            <= '0;
      win             <= '0;
      rr              <= '0;
      mem_req_valid_o <= 1'b0;
      res_valid_o     <= '0;
      res_data_o      <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (gany) begin
            win             <= gidx;
`ifdef TCORE_ARB_FIXED_PRIO_EN
            rr              <= '0;
`else
            rr              <= gidx;
`endif
            mreq.addr       <= gaddr & ~XLEN'(MB - 1);
            mreq.wmask      <= gwmask;
            mreq.data       <= gdata;
            mem_req_valid_o <= 1'b1;
            state           <= ARB_MREQ;
          end
        end
        // A response arriving together with the request accept is not legal and is dropped.
        ARB_MREQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            state           <= ARB_MWAIT;
          end
        end
        // Writes also return a response pulse; its data is forwarded as-is.
        ARB_MWAIT: begin
          if (mem_res_valid_i) begin
            res_data_o  <= mem_res_data_i;
            res_valid_o <= NUM_CH'(1) << win;
            state       <= ARB_CRESP;
          end
        end
        ARB_CRESP: begin
          if (res_ready_i[win]) begin
            res_valid_o <= '0;
            state       <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
